// File: rtl/aes_rkey_store.sv
// aes_rkey_store: drives the AES-128 key expander through one full schedule
// after a start pulse, captures the NR+1 round keys into a local register
// file, and serves any round key by index with one cycle of read latency.
// Optional macro AES_RKEY_ZEROIZE_EN adds a zeroize input that wipes the
// stored keys and the read register, and adds async clearing of storage.
module aes_rkey_store #(
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef AES_RKEY_ZEROIZE_EN
  input  logic             zeroize,
`endif
  input  logic             start,
  output logic             kx_kld,
  output logic             kx_enable,
  input  logic [31:0]      kx_rkey0,
  input  logic [31:0]      kx_rkey1,
  input  logic [31:0]      kx_rkey2,
  input  logic [31:0]      kx_rkey3,
  output logic             busy,
  output logic             key_ready,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [127:0]     rd_data
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXPAND,
    DONE
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);

  state_e           state_q;
  logic [IDX_W-1:0] cnt_q;
  logic             busy_q;
  logic             ready_q;
  logic [127:0]     rd_data_q;
  logic [127:0]     mem_q [NR+1];
  logic             zero_w;
  logic             last_w;

`ifdef AES_RKEY_ZEROIZE_EN
  assign zero_w = zeroize;
`else
  assign zero_w = 1'b0;
`endif

  assign last_w    = (cnt_q == LAST_IDX);
  assign kx_kld    = (state_q == LOAD) && !zero_w;
  assign kx_enable = (state_q == EXPAND) && !last_w && !zero_w;
  assign busy      = busy_q;
  assign key_ready = ready_q;
  assign rd_data   = rd_data_q;

  // Sequencing FSM: load the expander, step it NR times, then hold DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else if (zero_w) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          cnt_q   <= '0;
          state_q <= EXPAND;
        end
        EXPAND: begin
          if (last_w) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef AES_RKEY_ZEROIZE_EN
  // Round-key storage; wiped by reset or zeroize, otherwise filled during EXPAND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) mem_q[i] <= '0;
    end else if (zero_w) begin
      for (int i = 0; i <= NR; i++) mem_q[i] <= '0;
    end else if (state_q == EXPAND) begin
      mem_q[cnt_q] <= {kx_rkey0, kx_rkey1, kx_rkey2, kx_rkey3};
    end
  end
`else
  // Round-key storage; slot cnt takes the expander output each EXPAND cycle.
  always_ff @(posedge clk) begin
    if (state_q == EXPAND) begin
      mem_q[cnt_q] <= {kx_rkey0, kx_rkey1, kx_rkey2, kx_rkey3};
    end
  end
`endif

  // Registered read port; indices past the last round key read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (zero_w) begin
      rd_data_q <= '0;
    end else if (rd_idx > LAST_IDX) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_idx];
    end
  end

endmodule

// File: tb/tb_aes_rkey_store.sv
// tb_aes_rkey_store: self-checking bench for aes_rkey_store with a behavioural
// AES-128 key expander model feeding the kx_rkey inputs.
module tb_aes_rkey_store;

  localparam int NR    = 10;
  localparam int IDX_W = 4;

  localparam logic [127:0] KEY_A  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK10_A = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             kx_kld;
  logic             kx_enable;
  logic [31:0]      kx_rkey0;
  logic [31:0]      kx_rkey1;
  logic [31:0]      kx_rkey2;
  logic [31:0]      kx_rkey3;
  logic             busy;
  logic             key_ready;
  logic [IDX_W-1:0] rd_idx;
  logic [127:0]     rd_data;
`ifdef AES_RKEY_ZEROIZE_EN
  logic             zeroize;
`endif

  logic [127:0] keyIn;
  logic [127:0] kxState;
  logic [3:0]   kxRound;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] exp;
  } rdExp_t;

  rdExp_t sbQ[$];
  rdExp_t sbE;

  logic [7:0] sboxTab [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic logic [7:0] rconOf(input logic [3:0] r);
    case (r)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] nextKey(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sboxTab[w3[23:16]], sboxTab[w3[15:8]], sboxTab[w3[7:0]], sboxTab[w3[31:24]]};
    t  = t ^ {rc, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] roundKey(input logic [127:0] key, input int idx);
    logic [127:0] k;
    k = key;
    for (int r = 0; r < idx; r++) k = nextKey(k, rconOf(4'(r)));
    return k;
  endfunction

  // Behavioural key expander: kld loads the key, enable advances one round.
  always_ff @(posedge clk) begin
    if (kx_kld) begin
      kxState <= keyIn;
      kxRound <= 4'd0;
    end else if (kx_enable) begin
      kxState <= nextKey(kxState, rconOf(kxRound));
      kxRound <= kxRound + 4'd1;
    end
  end

  assign kx_rkey0 = kxState[127:96];
  assign kx_rkey1 = kxState[95:64];
  assign kx_rkey2 = kxState[63:32];
  assign kx_rkey3 = kxState[31:0];

  always #5 clk = ~clk;

  aes_rkey_store #(
    .NR    (NR),
    .IDX_W (IDX_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef AES_RKEY_ZEROIZE_EN
    .zeroize   (zeroize),
`endif
    .start     (start),
    .kx_kld    (kx_kld),
    .kx_enable (kx_enable),
    .kx_rkey0  (kx_rkey0),
    .kx_rkey1  (kx_rkey1),
    .kx_rkey2  (kx_rkey2),
    .kx_rkey3  (kx_rkey3),
    .busy      (busy),
    .key_ready (key_ready),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data)
  );

  // Pulses start and watches 16 cycles of handshake activity (sample i is after edge E_i).
  task automatic runExpansion(input logic [127:0] key, input int glitchAt,
                              input logic [127:0] glitchKey, output int readyIdx,
                              output int kldCnt, output int enCnt, output int overlap,
                              output int busyBad);
    readyIdx = -1;
    kldCnt   = 0;
    enCnt    = 0;
    overlap  = 0;
    busyBad  = 0;
    keyIn = key;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      start = (i == glitchAt);
      if (i == glitchAt) keyIn = glitchKey;
      if (kx_kld) kldCnt++;
      if (kx_enable) enCnt++;
      if (kx_kld && kx_enable) overlap++;
      if (key_ready && readyIdx < 0) readyIdx = i;
      if (busy !== (i <= 11)) busyBad++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    rd_idx = 4'd15;
    keyIn  = KEY_A;
`ifdef AES_RKEY_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    repeat (2) @(negedge clk);
    nCompared++;
    if (rd_data !== 128'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_rd_data: got %h expected 0", rd_data);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    nCompared++;
    if (busy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL idle_busy: got %b expected 0", busy);
    end
    nCompared++;
    if (key_ready !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL idle_key_ready: got %b expected 0", key_ready);
    end
    nCompared++;
    if (kx_kld !== 1'b0 || kx_enable !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL idle_kx: got kld=%b en=%b expected 0 0", kx_kld, kx_enable);
    end
    nCompared++;
    if (rd_data !== 128'h0) begin
      nMismatched++;
      $display("[TB] FAIL idle_rd_data: got %h expected 0", rd_data);
    end
  endtask

  task automatic test_expand_timing();
    int readyIdx, kldCnt, enCnt, overlap, busyBad;
    int idxList [3] = '{0, 5, 10};
    runExpansion(KEY_A, -1, KEY_A, readyIdx, kldCnt, enCnt, overlap, busyBad);
    nCompared++;
    if (kldCnt !== 1) begin
      nMismatched++;
      $display("[TB] FAIL kld_cycles: got %0d expected 1", kldCnt);
    end
    nCompared++;
    if (enCnt !== 10) begin
      nMismatched++;
      $display("[TB] FAIL enable_cycles: got %0d expected 10", enCnt);
    end
    nCompared++;
    if (overlap !== 0) begin
      nMismatched++;
      $display("[TB] FAIL kld_enable_overlap: got %0d expected 0", overlap);
    end
    nCompared++;
    if (readyIdx !== 12) begin
      nMismatched++;
      $display("[TB] FAIL ready_latency: got %0d expected 12", readyIdx);
    end
    nCompared++;
    if (busyBad !== 0) begin
      nMismatched++;
      $display("[TB] FAIL busy_window: got %0d bad cycles expected 0", busyBad);
    end
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k > 0) begin
        sbE = sbQ.pop_front();
        nCompared++;
        if (rd_data !== sbE.exp) begin
          nMismatched++;
          $display("[TB] FAIL keyA_rd[%0d]: got %h expected %h", sbE.idx, rd_data, sbE.exp);
        end
      end
      if (k < 3) begin
        rd_idx = 4'(idxList[k]);
        sbQ.push_back('{4'(idxList[k]),
                        (idxList[k] == 10) ? RK10_A :
                        (idxList[k] == 0)  ? KEY_A  : roundKey(KEY_A, idxList[k])});
      end
    end
  endtask

  task automatic test_back_to_back();
    int readyIdx, kldCnt, enCnt, overlap, busyBad;
    runExpansion(KEY_B, -1, KEY_B, readyIdx, kldCnt, enCnt, overlap, busyBad);
    nCompared++;
    if (readyIdx !== 12) begin
      nMismatched++;
      $display("[TB] FAIL keyB_ready_latency: got %0d expected 12", readyIdx);
    end
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      if (k > 0) begin
        sbE = sbQ.pop_front();
        nCompared++;
        if (rd_data !== sbE.exp) begin
          nMismatched++;
          $display("[TB] FAIL b2b_rd[%0d]: got %h expected %h", sbE.idx, rd_data, sbE.exp);
        end
      end
      if (k < 11) begin
        rd_idx = 4'(10 - k);
        sbQ.push_back('{4'(10 - k), (k == 0) ? RK10_B : (k == 10) ? KEY_B : roundKey(KEY_B, 10 - k)});
      end
    end
  endtask

  task automatic test_start_ignored();
    int readyIdx, kldCnt, enCnt, overlap, busyBad;
    runExpansion(KEY_A, 5, KEY_B, readyIdx, kldCnt, enCnt, overlap, busyBad);
    nCompared++;
    if (readyIdx !== 12) begin
      nMismatched++;
      $display("[TB] FAIL ignored_ready_latency: got %0d expected 12", readyIdx);
    end
    nCompared++;
    if (kldCnt !== 1) begin
      nMismatched++;
      $display("[TB] FAIL ignored_kld_cycles: got %0d expected 1", kldCnt);
    end
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      if (k > 0) begin
        sbE = sbQ.pop_front();
        nCompared++;
        if (rd_data !== sbE.exp) begin
          nMismatched++;
          $display("[TB] FAIL ignored_rd[%0d]: got %h expected %h", sbE.idx, rd_data, sbE.exp);
        end
      end
      if (k < 11) begin
        rd_idx = 4'(k);
        sbQ.push_back('{4'(k), roundKey(KEY_A, k)});
      end
    end
  endtask

  task automatic test_oob_and_reset();
    int readyIdx, kldCnt, enCnt, overlap, busyBad;
    int oobList [2] = '{15, 11};
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      if (k > 0) begin
        sbE = sbQ.pop_front();
        nCompared++;
        if (rd_data !== sbE.exp) begin
          nMismatched++;
          $display("[TB] FAIL oob_rd[%0d]: got %h expected 0", sbE.idx, rd_data);
        end
      end
      if (k < 2) begin
        rd_idx = 4'(oobList[k]);
        sbQ.push_back('{4'(oobList[k]), 128'h0});
      end
    end
    rd_idx = 4'd3;
    keyIn  = KEY_A;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    nCompared++;
    if (busy !== 1'b0 || key_ready !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL midexpand_reset: got busy=%b ready=%b expected 0 0", busy, key_ready);
    end
    nCompared++;
    if (kx_enable !== 1'b0 || rd_data !== 128'h0) begin
      nMismatched++;
      $display("[TB] FAIL midexpand_reset_out: got en=%b rd=%h expected 0 0", kx_enable, rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    runExpansion(KEY_B, -1, KEY_B, readyIdx, kldCnt, enCnt, overlap, busyBad);
    nCompared++;
    if (readyIdx !== 12 || enCnt !== 10) begin
      nMismatched++;
      $display("[TB] FAIL restart_timing: got ready@%0d en=%0d expected 12 10", readyIdx, enCnt);
    end
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      if (k > 0) begin
        sbE = sbQ.pop_front();
        nCompared++;
        if (rd_data !== sbE.exp) begin
          nMismatched++;
          $display("[TB] FAIL restart_rd[%0d]: got %h expected %h", sbE.idx, rd_data, sbE.exp);
        end
      end
      if (k < 11) begin
        rd_idx = 4'(k);
        sbQ.push_back('{4'(k), roundKey(KEY_B, k)});
      end
    end
    rst_n = 1'b0;
    #1;
    nCompared++;
    if (key_ready !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL done_reset_ready: got %b expected 0", key_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef AES_RKEY_ZEROIZE_EN
  task automatic test_zeroize();
    int readyIdx, kldCnt, enCnt, overlap, busyBad;
    runExpansion(KEY_A, -1, KEY_A, readyIdx, kldCnt, enCnt, overlap, busyBad);
    nCompared++;
    if (key_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL zeroize_pre_ready: got %b expected 1", key_ready);
    end
    zeroize = 1'b1;
    start   = 1'b1;
    rd_idx  = 4'd10;
    @(negedge clk);
    zeroize = 1'b0;
    start   = 1'b0;
    nCompared++;
    if (key_ready !== 1'b0 || busy !== 1'b0 || kx_kld !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL zeroize_state: got ready=%b busy=%b kld=%b expected 0 0 0",
               key_ready, busy, kx_kld);
    end
    nCompared++;
    if (rd_data !== 128'h0) begin
      nMismatched++;
      $display("[TB] FAIL zeroize_rd_clear: got %h expected 0", rd_data);
    end
    @(negedge clk);
    nCompared++;
    if (rd_data !== 128'h0 || kx_kld !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL zeroize_mem10: got rd=%h kld=%b expected 0 0", rd_data, kx_kld);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting aes_rkey_store bench");
    test_reset();
    test_expand_timing();
    test_back_to_back();
    test_start_ignored();
    test_oob_and_reset();
`ifdef AES_RKEY_ZEROIZE_EN
    test_zeroize();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/aes_rkey_store.md
Name: aes_rkey_store

Overview:
- Sequences the 128-bit key expander (kld/enable control) immediately after a new key is presented.
- Captures all NR+1 round keys it produces into a local register file.
- Serves any round key by index with one-cycle read latency, so the inverse cipher can walk round keys in reverse order (10 down to 0).
- Sits between the key expander (upstream) and the decrypt datapath (downstream).

Parameters:
- NR, 10, number of AES rounds. NR+1 keys are stored. Only 10 (AES-128) is supported.
- IDX_W, 4, width of the round-key index. Must satisfy 2^IDX_W > NR.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse: begin expansion of the key currently applied to the expander's key input.
- kx_kld  out  1  to expander kld.
- kx_enable  out  1  to expander enable.
- kx_rkey0  in  32  expander w[0]; bits [127:96] of the stored key.
- kx_rkey1  in  32  expander w[1]; bits [95:64].
- kx_rkey2  in  32  expander w[2]; bits [63:32].
- kx_rkey3  in  32  expander w[3]; bits [31:0].
- busy  out  1  expansion in progress.
- key_ready  out  1  all NR+1 round keys valid.
- rd_idx  in  IDX_W  round-key index to read.
- rd_data  out  128  registered round key for rd_idx, valid 1 cycle after rd_idx is sampled.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE, cnt=0, kx_kld=0, kx_enable=0, busy=0, key_ready=0, rd_data=0. Storage need not be reset unless AES_RKEY_ZEROIZE_EN is defined.
- FSM states:
  - IDLE: start=1 -> LOAD.
  - LOAD: kx_kld=1 for exactly this one cycle; busy=1; key_ready=0; cnt<=0. -> EXPAND.
  - EXPAND:
    - busy=1.
    - Each cycle, mem[cnt] <= {kx_rkey0,kx_rkey1,kx_rkey2,kx_rkey3}.
    - kx_enable = (cnt != NR).
    - cnt<NR: cnt++.
    - cnt==NR: -> DONE.
  - DONE: key_ready=1, busy=0. start=1 -> LOAD (key_ready drops the following cycle).
- kx_kld and kx_enable are combinational decodes of state/cnt. They are never high simultaneously.
- Timing: start sampled at edge E0 -> expander loads at E1 -> slots 0..NR captured at E2..E12 -> key_ready=1 from E12 on. Total 12 cycles, start to key_ready.
- start while busy (LOAD or EXPAND) is ignored; the current expansion completes unchanged.
- Read path:
  - rd_data <= mem[rd_idx] every cycle, regardless of key_ready.
  - rd_idx > NR gives rd_data <= 0.
  - Reads during EXPAND return the old content for slots not yet overwritten.
  - A read of a slot on the same edge it is written returns the old value (no bypass).
- Reset mid-operation: FSM returns to IDLE asynchronously, key_ready=0. The next start restarts from LOAD.
- rd_data is always a registered output, never combinational from rd_idx.

Optional Feature:
- Macro: AES_RKEY_ZEROIZE_EN.
- Defined:
  - Extra input port zeroize (1 bit).
  - zeroize=1 in any state: all mem slots and rd_data cleared to 0 over the next edge; FSM -> IDLE; key_ready=0; kx_kld and kx_enable forced to 0 that cycle.
  - zeroize has priority over start.
  - Asynchronous reset also clears mem.
- Not defined: no zeroize port; mem is not reset; behaviour is otherwise identical.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, key_ready=0, kx_kld=0, kx_enable=0, rd_data=0.
- Expander key 000102030405060708090a0b0c0d0e0f, start pulse -> kx_kld high exactly 1 cycle, kx_enable high 10 cycles, key_ready high 12 cycles after start. rd_idx=0 -> 000102030405060708090a0b0c0d0e0f; rd_idx=10 -> 13111d7fe3944a17f307a78b4d2b30c5.
- Key 2b7e151628aed2a6abf7158809cf4f3c, read rd_idx 10 down to 0 back-to-back -> first data d014f9a8c9ee2589e13f0cc8b6630ca6 one cycle after rd_idx=10; last data 2b7e151628aed2a6abf7158809cf4f3c.
- start re-pulsed 4 cycles into EXPAND -> ignored: key_ready still rises at cycle 12 and stored keys match the first key.
- rd_idx=15 -> rd_data=0. rst_n low during EXPAND -> busy and key_ready low immediately. start after release -> correct keys again.
- With AES_RKEY_ZEROIZE_EN: in DONE, zeroize=1 together with start -> next cycle key_ready=0, state IDLE, rd_idx=10 reads 0, no kx_kld pulse.
